// File: rtl/ir_seq_pkg.sv
// ----------------------------------------------------------------------------
// ir_seq_pkg
// Shared types and helpers for the IR line-sensor scan sequencer.
//   seq_state_e : scan FSM states
//   lft_chnl    : A2D channel of the left sensor of pair k
//   rht_chnl    : A2D channel of the right sensor of pair k
//   sat         : clamp a signed value into a w-bit signed range
// ----------------------------------------------------------------------------
package ir_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    WAIT_L = 3'd2,
    WAIT_R = 3'd3,
    DONE   = 3'd4
  } seq_state_e;

  function automatic int lft_chnl(input int k);
    return 2 * k;
  endfunction

  function automatic int rht_chnl(input int k);
    return 2 * k + 1;
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/ir_err_accum.sv
// ----------------------------------------------------------------------------
// ir_err_accum
// Signed shift-accumulate of per-pair (rht - lft) differences, with the
// running sum presented saturated to ACC_W bits.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears the sum)
//   clr       : zero the sum (start of a scan)
//   add_en    : add diff <<< shift to the sum
//   shift     : pair index k, weight 2**k
//   diff      : signed RES_W+1 bit difference rht - lft
//   sat_out   : sum clamped to the signed ACC_W range
// ----------------------------------------------------------------------------
module ir_err_accum
  import ir_seq_pkg::*;
#(
  parameter int RES_W     = 12,
  parameter int NUM_PAIRS = 3,
  parameter int ACC_W     = 16,
  parameter int K_W       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    add_en,
  input  logic [K_W-1:0]          shift,
  input  logic signed [RES_W:0]   diff,
  output logic signed [ACC_W-1:0] sat_out
);

  // Wide enough for every pair at full-scale difference: no wrap possible.
  localparam int AW = RES_W + NUM_PAIRS + 1;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] diff_ext;

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [AW-1:0] v);
    logic signed [63:0] wide;
    wide = {{(64 - AW){v[AW-1]}}, v};
    return ACC_W'(sat(wide, ACC_W));
  endfunction

  assign diff_ext = {{(AW - RES_W - 1){diff[RES_W]}}, diff};

  always_ff @(posedge clk) begin
    if (rst)         acc <= '0;
    else if (clr)    acc <= '0;
    else if (add_en) acc <= acc + (diff_ext <<< shift);
  end

  assign sat_out = sat_acc(acc);

endmodule

// File: rtl/ir_chnl_sequencer.sv
// ----------------------------------------------------------------------------
// ir_chnl_sequencer
// Scans NUM_PAIRS IR emitter/receiver pairs: enables emitter k, waits
// SETTLE_CYC cycles, converts left (chnnl 2k) then right (chnnl 2k+1) through
// the A2D strt_cnv/cnv_cmplt handshake, accumulates (rht-lft)<<k and
// publishes a saturated signed error with a one-cycle err_vld pulse.
// Optional macro SEQ_TIMEOUT_EN adds a cnv_cmplt watchdog (TIMEOUT_CYC).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   go         : level, 1 = scan continuously, 0 = idle / abort
//   cnv_cmplt  : A2D conversion done pulse, res valid with it
//   res        : A2D result (unsigned RES_W)
//   strt_cnv   : one-cycle conversion request
//   chnnl      : A2D channel, held from strt_cnv until cnv_cmplt
//   ir_en      : one-hot (or zero) emitter enable
//   err        : saturated signed weighted error of last complete scan
//   err_vld    : one-cycle pulse when err updates
//   busy       : FSM not in IDLE
//   timeout    : sticky watchdog flag (0 without SEQ_TIMEOUT_EN)
// ----------------------------------------------------------------------------
module ir_chnl_sequencer
  import ir_seq_pkg::*;
#(
  parameter int NUM_PAIRS   = 3,
  parameter int RES_W       = 12,
  parameter int CHNL_W      = 3,
  parameter int SETTLE_CYC  = 4096,
  parameter int ACC_W       = 16,
  parameter int TIMEOUT_CYC = 8192
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic                    cnv_cmplt,
  input  logic [RES_W-1:0]        res,
  output logic                    strt_cnv,
  output logic [CHNL_W-1:0]       chnnl,
  output logic [NUM_PAIRS-1:0]    ir_en,
  output logic signed [ACC_W-1:0] err,
  output logic                    err_vld,
  output logic                    busy,
  output logic                    timeout
);

  localparam int K_W     = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_PAIRS - 1);

  seq_state_e state, state_nxt;

  logic [K_W-1:0]          k;
  logic [CNT_W-1:0]        cnt;
  logic [RES_W-1:0]        lft;
  logic signed [RES_W:0]   diff;
  logic signed [ACC_W-1:0] err_sat;

  logic start, abort, settle_last, cap_l, add_r, tmo_hit;
  logic go_block, wait_expired, go_start;

`ifdef SEQ_TIMEOUT_EN
  // cnt restarts on every strt_cnv, so it measures time spent waiting.
  assign wait_expired = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // After a watchdog trip go must fall before another scan may start.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout  <= 1'b0;
      go_block <= 1'b0;
    end else if (tmo_hit) begin
      timeout  <= 1'b1;
      go_block <= 1'b1;
    end else if (!go) begin
      go_block <= 1'b0;
    end
  end
`else
  assign wait_expired = 1'b0;
  assign go_block     = 1'b0;
  assign timeout      = 1'b0;
`endif

  assign go_start = go && !go_block;
  assign busy     = (state != IDLE);
  assign diff     = $signed({1'b0, res}) - $signed({1'b0, lft});

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Abort (go low) takes priority over a coincident cnv_cmplt.
  always_comb begin
    state_nxt   = state;
    start       = 1'b0;
    abort       = 1'b0;
    settle_last = 1'b0;
    cap_l       = 1'b0;
    add_r       = 1'b0;
    tmo_hit     = 1'b0;
    case (state)
      IDLE: begin
        if (go_start) begin
          start     = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (!go) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (ir_en != '0 && cnt == CNT_W'(SETTLE_CYC - 1)) begin
          settle_last = 1'b1;
          state_nxt   = WAIT_L;
        end
      end
      WAIT_L: begin
        if (!go) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (cnv_cmplt) begin
          cap_l     = 1'b1;
          state_nxt = WAIT_R;
        end else if (wait_expired) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_R: begin
        if (!go) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (cnv_cmplt) begin
          add_r     = 1'b1;
          state_nxt = (k == K_LAST) ? DONE : SETTLE;
        end else if (wait_expired) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE: begin
        if (go_start) begin
          start     = 1'b1;
          state_nxt = SETTLE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Between pairs ir_en is cleared on the right-channel completion; the
  // first SETTLE cycle re-enables the next emitter without counting, so each
  // pair sees SETTLE_CYC cycles of emitter-on before its first conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      k        <= '0;
      cnt      <= '0;
      lft      <= '0;
      strt_cnv <= 1'b0;
      chnnl    <= '0;
      ir_en    <= '0;
      err      <= '0;
      err_vld  <= 1'b0;
    end else begin
      strt_cnv <= 1'b0;
      err_vld  <= 1'b0;
      case (state)
        SETTLE: begin
          if (go) begin
            if (ir_en == '0) begin
              ir_en <= NUM_PAIRS'(1) << k;
            end else if (settle_last) begin
              strt_cnv <= 1'b1;
              chnnl    <= CHNL_W'(lft_chnl(int'(k)));
              cnt      <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WAIT_L: begin
          if (cap_l) begin
            lft      <= res;
            strt_cnv <= 1'b1;
            chnnl    <= CHNL_W'(rht_chnl(int'(k)));
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_R: begin
          if (add_r) begin
            ir_en <= '0;
            cnt   <= '0;
            if (k != K_LAST) k <= k + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          err     <= err_sat;
          err_vld <= 1'b1;
        end
        default: ;
      endcase
      if (start) begin
        k     <= '0;
        cnt   <= '0;
        ir_en <= NUM_PAIRS'(1);
      end
      if (abort || tmo_hit) ir_en <= '0;
    end
  end

  ir_err_accum #(
    .RES_W     (RES_W),
    .NUM_PAIRS (NUM_PAIRS),
    .ACC_W     (ACC_W),
    .K_W       (K_W)
  ) u_accum (
    .clk     (clk),
    .rst     (rst),
    .clr     (start),
    .add_en  (add_r),
    .shift   (k),
    .diff    (diff),
    .sat_out (err_sat)
  );

endmodule

// File: tb/tb_ir_chnl_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ir_chnl_sequencer
// Scoreboard bench: stimulus pushes expected channel order and expected err
// values; a monitor pops and compares whenever strt_cnv or err_vld appears.
// An A2D model answers each strt_cnv after a fixed latency with the value
// assigned to that channel. The expected err is the saturated weighted sum
// of per-pair differences.
// ----------------------------------------------------------------------------
module tb_ir_chnl_sequencer;

  localparam int NP  = 3;
  localparam int RW  = 12;
  localparam int CW  = 3;
  localparam int SC  = 8;
  localparam int AW  = 12;
  localparam int TC  = 50;
  localparam int LAT = 20;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 go;
  logic                 cnv_cmplt;
  logic [RW-1:0]        res;
  logic                 strt_cnv;
  logic [CW-1:0]        chnnl;
  logic [NP-1:0]        ir_en;
  logic signed [AW-1:0] err;
  logic                 err_vld;
  logic                 busy;
  logic                 timeout;

  ir_chnl_sequencer #(
    .NUM_PAIRS   (NP),
    .RES_W       (RW),
    .CHNL_W      (CW),
    .SETTLE_CYC  (SC),
    .ACC_W       (AW),
    .TIMEOUT_CYC (TC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .cnv_cmplt (cnv_cmplt),
    .res       (res),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .ir_en     (ir_en),
    .err       (err),
    .err_vld   (err_vld),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial forever #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ch_q[$];
  int err_q[$];
  int last_err = 0;
  int vld_cnt  = 0;
  int chan_val[6];
  bit a2d_suppress = 1'b0;
  int cmplt_ch = -1;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: err = clamp(sum_k (rht_k - lft_k) * 2**k) to signed AW bits.
  function automatic int model_err();
    int s;
    int hi;
    int lo;
    s = 0;
    for (int p = 0; p < NP; p++) s += (chan_val[2*p+1] - chan_val[2*p]) * (1 << p);
    hi = (1 << (AW - 1)) - 1;
    lo = -(1 << (AW - 1));
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return s;
  endfunction

  // A2D model: answer each strt_cnv LAT cycles later.
  initial begin
    int pend;
    int pend_ch;
    pend = 0;
    pend_ch = 0;
    cnv_cmplt = 1'b0;
    res = '0;
    forever begin
      @(negedge clk);
      cnv_cmplt = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          cnv_cmplt = 1'b1;
          res = RW'(chan_val[pend_ch]);
          cmplt_ch = pend_ch;
        end
      end
      if (strt_cnv === 1'b1 && !a2d_suppress) begin
        pend = LAT;
        pend_ch = int'(chnnl) % 6;
      end
    end
  end

  // Monitor
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (strt_cnv === 1'b1) begin
        if (ch_q.size() == 0) chk("strt_unexpected", strt_cnv, 0);
        else begin
          e = ch_q.pop_front();
          chk("chnnl", chnnl, e);
          chk("ir_en_at_strt", ir_en, 1 << (e / 2));
        end
      end
      if (err_vld === 1'b1) begin
        vld_cnt++;
        if (err_q.size() == 0) chk("err_vld_unexpected", err_vld, 0);
        else begin
          e = err_q.pop_front();
          chk("err", $signed(err), e);
          last_err = e;
        end
      end
    end
  end

  task automatic push_scan(input int nch, input bit full);
    for (int i = 0; i < nch; i++) ch_q.push_back(i);
    if (full) err_q.push_back(model_err());
  endtask

  task automatic wait_strt(input int ch);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(strt_cnv === 1'b1 && int'(chnnl) == ch) && n < 400);
    chk("strt_seen", {strt_cnv, chnnl}, {1'b1, 3'(ch)});
  endtask

  task automatic wait_cmplt_edge(input int ch);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!(cnv_cmplt === 1'b1 && cmplt_ch == ch) && n < 600);
    chk("cmplt_seen", (cnv_cmplt === 1'b1 && cmplt_ch == ch), 1);
  endtask

  // Single scan; go is dropped during DONE so exactly one err_vld results.
  task automatic run_scan();
    push_scan(6, 1'b1);
    @(negedge clk);
    go = 1'b1;
    wait_cmplt_edge(5);
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic set_vals(input int l0, r0, l1, r1, l2, r2);
    chan_val[0] = l0; chan_val[1] = r0;
    chan_val[2] = l1; chan_val[3] = r1;
    chan_val[4] = l2; chan_val[5] = r2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int v0;
    rst = 1'b1;
    go  = 1'b0;
    set_vals(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_strt_cnv", strt_cnv, 0);
    chk("rst_chnnl", chnnl, 0);
    chk("rst_ir_en", ir_en, 0);
    chk("rst_err", $signed(err), 0);
    chk("rst_err_vld", err_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal scan with latency measurement to the first strt_cnv.
    set_vals('h100, 'h180, 'h200, 'h100, 'h300, 'h300);
    push_scan(6, 1'b1);
    v0 = vld_cnt;
    go = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (strt_cnv !== 1'b1 && n < 100);
    chk("first_strt_latency", n, SC + 1);
    chk("busy_in_scan", busy, 1);
    wait_cmplt_edge(5);
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_nominal", $signed(err), -384);
    chk("nominal_vld_pulses", vld_cnt - v0, 1);
    chk("idle_after_scan", busy, 0);

    // Back-to-back scans: go stays high across DONE.
    set_vals(10, 400, 700, 20, 5, 90);
    push_scan(6, 1'b1);
    @(negedge clk);
    go = 1'b1;
    wait_cmplt_edge(5);
    @(negedge clk);
    set_vals(300, 50, 60, 900, 1000, 999);
    push_scan(6, 1'b1);
    wait_cmplt_edge(5);
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);

    // Saturation both ways.
    set_vals(0, 'hFFF, 0, 'hFFF, 0, 'hFFF);
    run_scan();
    chk("err_sat_pos", $signed(err), 2047);
    set_vals('hFFF, 0, 'hFFF, 0, 'hFFF, 0);
    run_scan();
    chk("err_sat_neg", $signed(err), -2048);

    // Random scans: small values stay in range, full-scale ones may clamp.
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < 6; c++)
        chan_val[c] = (i % 2 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 4095));
      run_scan();
    end

    // Abort in WAIT_R of pair 1.
    set_vals(1, 2, 3, 4, 5, 6);
    push_scan(4, 1'b0);
    v0 = vld_cnt;
    @(negedge clk);
    go = 1'b1;
    wait_strt(3);
    repeat (5) @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_ir_en", ir_en, 0);
    chk("abort_err_held", $signed(err), last_err);
    repeat (30) @(negedge clk);
    chk("abort_late_cmplt_busy", busy, 0);
    chk("abort_no_vld", vld_cnt - v0, 0);
    chk("abort_err_still_held", $signed(err), last_err);

    // Reset during WAIT_L.
    push_scan(1, 1'b0);
    @(negedge clk);
    go = 1'b1;
    wait_strt(0);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    go  = 1'b0;
    @(negedge clk);
    chk("mid_rst_strt_cnv", strt_cnv, 0);
    chk("mid_rst_chnnl", chnnl, 0);
    chk("mid_rst_ir_en", ir_en, 0);
    chk("mid_rst_err", $signed(err), 0);
    chk("mid_rst_err_vld", err_vld, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_timeout", timeout, 0);
    rst = 1'b0;
    last_err = 0;
    repeat (30) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_err", $signed(err), 0);

`ifdef SEQ_TIMEOUT_EN
    a2d_suppress = 1'b1;
    push_scan(1, 1'b0);
    @(negedge clk);
    go = 1'b1;
    wait_strt(0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (timeout !== 1'b1 && n < 200);
    chk("timeout_latency", n, TC);
    chk("timeout_busy", busy, 0);
    chk("timeout_ir_en", ir_en, 0);
    repeat (20) @(negedge clk);
    chk("timeout_no_restart", busy, 0);
    go = 1'b0;
    repeat (3) @(negedge clk);
    chk("timeout_sticky", timeout, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("timeout_cleared", timeout, 0);
    a2d_suppress = 1'b0;
`else
    chk("timeout_tied", timeout, 0);
`endif

    // Recovery scan after abort/reset.
    for (int c = 0; c < 6; c++) chan_val[c] = int'($urandom_range(0, 4095));
    run_scan();

    repeat (5) @(negedge clk);
    chk("ch_q_drained", ch_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
